// File: rtl/regfile_sb.sv
// regfile_sb: parametrised integer register file with x0 hard-wired to zero, write-to-read bypass,
// per-register busy scoreboard and a sequential soft-clear engine (one register per cycle).
// Reads are combinational (0 cycles); writes and issues commit on the rising edge; the clear takes DEPTH cycles.
module regfile_sb #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 32,
  parameter int AW     = $clog2(DEPTH),
  parameter int NUM_RD = 2,
  parameter int BYPASS = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_RD*AW-1:0]    rr_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]       rd_busy,
  input  logic                    reg_write,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    issue_valid,
  input  logic [AW-1:0]           issue_addr,
  input  logic                    clr_req,
  output logic                    clr_busy,
  output logic                    clr_done
);

  typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             clr_done_q, clr_done_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0] busy_q, busy_d;

  // Next-state: writes/issues in IDLE, one register zeroed per cycle in CLEAR.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_done_d = 1'b0;
    mem_d      = mem_q;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (reg_write && (wr_addr != '0)) begin
          mem_d[wr_addr]  = wr_data;
          busy_d[wr_addr] = 1'b0;
        end
        // Issue is applied after the write so a same-cycle new producer leaves the register busy.
        if (issue_valid && (issue_addr != '0)) begin
          busy_d[issue_addr] = 1'b1;
        end
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        mem_d[idx_q]  = '0;
        busy_d[idx_q] = 1'b0;
        idx_d         = idx_q + 1'b1;
        if (idx_q == AW'(DEPTH - 1)) begin
          state_d    = IDLE;
          idx_d      = '0;
          clr_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, array and scoreboard registers; reset aborts any clear in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      clr_done_q <= 1'b0;
      busy_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      clr_done_q <= clr_done_d;
      busy_q     <= busy_d;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Combinational read ports: x0 reads zero/not busy; a matching IDLE write is forwarded when enabled.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rr_addr[k*AW +: AW] != '0) begin
        rd_data[k*WIDTH +: WIDTH] = mem_q[rr_addr[k*AW +: AW]];
        rd_busy[k]                = busy_q[rr_addr[k*AW +: AW]];
        if ((BYPASS != 0) && (state_q == IDLE) && reg_write &&
            (wr_addr == rr_addr[k*AW +: AW])) begin
          rd_data[k*WIDTH +: WIDTH] = wr_data;
          rd_busy[k]                = 1'b0;
        end
      end
    end
  end

  assign clr_busy = (state_q == CLEAR);
  assign clr_done = clr_done_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed test of regfile_sb in three configurations
// (default with bypass, default without bypass, 64-bit x 16 x 3 ports).
// Inputs are driven 1 ns after the rising edge; outputs are checked before the next edge.
module tb_regfile_sb;

  logic clk;
  logic rst;

  // Shared stimulus for the two 32x32 instances.
  logic [9:0]  rr_addr;
  logic        reg_write;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        clr_req;
  logic [63:0] rd_data, rd_data_nb;
  logic [1:0]  rd_busy, rd_busy_nb;
  logic        clr_busy, clr_done, clr_busy_nb, clr_done_nb;

  // Stimulus for the 64-bit, 16-entry, 3-port instance.
  logic [11:0]  p_rr_addr;
  logic         p_reg_write;
  logic [3:0]   p_wr_addr;
  logic [63:0]  p_wr_data;
  logic         p_issue_valid;
  logic [3:0]   p_issue_addr;
  logic         p_clr_req;
  logic [191:0] p_rd_data;
  logic [2:0]   p_rd_busy;
  logic         p_clr_busy, p_clr_done;

  int n_chk  = 0;
  int n_pass = 0;

  regfile_sb dut (
    .clk(clk), .rst(rst), .rr_addr(rr_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .reg_write(reg_write), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  regfile_sb #(.BYPASS(0)) dut_nb (
    .clk(clk), .rst(rst), .rr_addr(rr_addr), .rd_data(rd_data_nb), .rd_busy(rd_busy_nb),
    .reg_write(reg_write), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_valid(issue_valid), .issue_addr(issue_addr),
    .clr_req(clr_req), .clr_busy(clr_busy_nb), .clr_done(clr_done_nb)
  );

  regfile_sb #(.WIDTH(64), .DEPTH(16), .NUM_RD(3)) dut_p (
    .clk(clk), .rst(rst), .rr_addr(p_rr_addr), .rd_data(p_rd_data), .rd_busy(p_rd_busy),
    .reg_write(p_reg_write), .wr_addr(p_wr_addr), .wr_data(p_wr_data),
    .issue_valid(p_issue_valid), .issue_addr(p_issue_addr),
    .clr_req(p_clr_req), .clr_busy(p_clr_busy), .clr_done(p_clr_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int cnt;
  int ndone;

  initial begin
    rst = 1'b1;
    rr_addr = '0; reg_write = 1'b0; wr_addr = '0; wr_data = '0;
    issue_valid = 1'b0; issue_addr = '0; clr_req = 1'b0;
    p_rr_addr = '0; p_reg_write = 1'b0; p_wr_addr = '0; p_wr_data = '0;
    p_issue_valid = 1'b0; p_issue_addr = '0; p_clr_req = 1'b0;
    rr_addr = {5'd2, 5'd1};
    #3;
    chk("rst_data", rd_data, 64'd0);
    chk("rst_busy", {62'd0, rd_busy}, 64'd0);
    chk("rst_clr_busy", {63'd0, clr_busy}, 64'd0);
    chk("rst_clr_done", {63'd0, clr_done}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    tick();

    // x0 write is dropped, both through bypass and the array.
    reg_write = 1'b1; wr_addr = 5'd0; wr_data = 32'hDEADBEEF; rr_addr = {5'd0, 5'd0};
    #1 chk("x0_bypass", rd_data, 64'd0);
    tick(); reg_write = 1'b0;
    #1 chk("x0_read", rd_data, 64'd0);

    // x6 = 25 with both ports reading x6.
    reg_write = 1'b1; wr_addr = 5'd6; wr_data = 32'd25; rr_addr = {5'd6, 5'd6};
    #1 chk("x6_bypass", rd_data, {32'd25, 32'd25});
    chk("x6_nobypass_old", rd_data_nb, 64'd0);
    tick(); reg_write = 1'b0;
    #1 chk("x6_after", rd_data, {32'd25, 32'd25});
    chk("x6_nb_after", rd_data_nb, {32'd25, 32'd25});

    // Scoreboard: issue x4, then write it.
    issue_valid = 1'b1; issue_addr = 5'd4; rr_addr = {5'd0, 5'd4};
    #1 chk("x4_busy_pre", {62'd0, rd_busy}, 64'd0);
    tick(); issue_valid = 1'b0;
    #1 chk("x4_busy", {62'd0, rd_busy}, 64'd1);
    reg_write = 1'b1; wr_addr = 5'd4; wr_data = 32'd7;
    #1 chk("x4_bypass_busy", {62'd0, rd_busy}, 64'd0);
    chk("x4_bypass_data", rd_data, 64'd7);
    chk("x4_nb_busy_pre", {62'd0, rd_busy_nb}, 64'd1);
    tick(); reg_write = 1'b0;
    #1 chk("x4_busy_after", {62'd0, rd_busy}, 64'd0);
    chk("x4_nb_data", rd_data_nb, 64'd7);

    // Same-cycle issue and write to x8: data lands, busy stays set.
    reg_write = 1'b1; wr_addr = 5'd8; wr_data = 32'h88;
    issue_valid = 1'b1; issue_addr = 5'd8; rr_addr = {5'd8, 5'd4};
    tick(); reg_write = 1'b0; issue_valid = 1'b0;
    #1 chk("x8_busy", {62'd0, rd_busy}, 64'd2);
    chk("x8_data", rd_data, {32'h88, 32'd7});

    // Mid-run reset wipes data and busy.
    rst = 1'b1;
    #1 chk("midrst_data", rd_data, 64'd0);
    chk("midrst_busy", {62'd0, rd_busy}, 64'd0);
    @(posedge clk); #1 rst = 1'b0;

    // Preload x1..x31, mark x5 and x9 busy.
    for (int i = 1; i < 32; i++) begin
      reg_write = 1'b1; wr_addr = 5'(i); wr_data = 32'h1000 + 32'(i);
      tick();
    end
    reg_write = 1'b0;
    issue_valid = 1'b1; issue_addr = 5'd5; tick();
    issue_addr = 5'd9; tick();
    issue_valid = 1'b0;
    rr_addr = {5'd5, 5'd31};
    #1 chk("pre_x31", rd_data[31:0], 64'h101F);
    chk("pre_x5_busy", {62'd0, rd_busy}, 64'd2);

    // Soft clear with writes/issues hammering during CLEAR.
    clr_req = 1'b1;
    #1 chk("clr_busy_not_yet", {63'd0, clr_busy}, 64'd0);
    tick(); clr_req = 1'b0;
    cnt = 0; ndone = 0;
    for (int c = 0; c < 100; c++) begin
      if (clr_done) ndone++;
      if (!clr_busy) break;
      cnt++;
      reg_write   = (cnt < 20); wr_addr = 5'd2; wr_data = 32'hBAD;
      issue_valid = (cnt < 20); issue_addr = 5'd3;
      rr_addr = {5'd3, 5'd2};
      if (cnt == 10) begin
        #1 chk("clear_no_bypass", rd_data[31:0], 64'd0);
      end
      tick();
    end
    reg_write = 1'b0; issue_valid = 1'b0;
    chk("clear_len", 64'(cnt), 64'd32);
    tick();
    chk("clr_done_once", 64'(ndone), 64'd1);
    chk("clr_done_low", {63'd0, clr_done}, 64'd0);
    for (int i = 0; i < 32; i++) begin
      rr_addr = {5'(i), 5'(i)};
      #1 chk($sformatf("clr_x%0d", i), {rd_data[31:0], 30'd0, rd_busy}, 64'd0);
    end

    // Reset 10 cycles into a clear aborts it without clr_done.
    reg_write = 1'b1; wr_addr = 5'd7; wr_data = 32'h77; tick(); reg_write = 1'b0;
    clr_req = 1'b1; tick(); clr_req = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    rr_addr = {5'd0, 5'd7};
    rst = 1'b1;
    #1 chk("rstclr_busy", {63'd0, clr_busy}, 64'd0);
    chk("rstclr_data", rd_data, 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      if (clr_done || clr_busy) ndone++;
      tick();
    end
    chk("rstclr_no_done", 64'(ndone), 64'd0);

    // 64-bit, 16-entry, 3-port configuration.
    p_reg_write = 1'b1; p_wr_addr = 4'd15; p_wr_data = 64'hFFFF_FFFF_0000_0001;
    p_rr_addr = {4'd15, 4'd15, 4'd15};
    tick(); p_reg_write = 1'b0;
    #1 chk("p_port0", p_rd_data[63:0], 64'hFFFF_FFFF_0000_0001);
    chk("p_port1", p_rd_data[127:64], 64'hFFFF_FFFF_0000_0001);
    chk("p_port2", p_rd_data[191:128], 64'hFFFF_FFFF_0000_0001);
    p_clr_req = 1'b1; tick(); p_clr_req = 1'b0;
    cnt = 0; ndone = 0;
    for (int c = 0; c < 100; c++) begin
      if (p_clr_done) ndone++;
      if (!p_clr_busy) break;
      cnt++;
      tick();
    end
    chk("p_clear_len", 64'(cnt), 64'd16);
    chk("p_clr_done", 64'(ndone), 64'd1);
    chk("p_cleared", p_rd_data[63:0], 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  // Safety net in case a wait above never resolves.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
